uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit period (legal range 2..65535).
REQ-002 Parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit between data and stop.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  byte to transmit; sampled only on an accepted handshake.
REQ-006 tx_valid  input  1  producer offers tx_data.
REQ-007 tx_ready  output  1  one-entry holding register is empty; transfer occurs when tx_valid && tx_ready at a rising edge.
REQ-008 tx  output  1  serial line, registered, idle high; drives the downstream receiver's Rx input.
REQ-009 busy  output  1  high while a frame is in progress or the holding register is full.

Function
REQ-010 The frame SHALL be: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1; each bit exactly CLKS_PER_BIT cycles.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-012 An accepted byte SHALL enter the holding register; tx_ready SHALL be the registered negation of hold_full.
REQ-013 In IDLE with hold_full=1, the FSM SHALL, on the next edge, move the byte to the shift register, clear hold_full, enter START and drive tx=0 (start bit begins one cycle after the accepting edge).
REQ-014 The baud counter SHALL count 0..CLKS_PER_BIT-1 and the FSM SHALL advance only on the cycle in which it wraps.
REQ-015 DATA SHALL use a 3-bit index 0..7; the FSM SHALL leave DATA when the index wraps from 7 at a bit boundary.
REQ-016 The parity bit SHALL be the XOR of the 8 transmitted data bits (even parity).
REQ-017 At the end of STOP, if hold_full=1 the FSM SHALL go directly to START with zero idle cycles; otherwise it SHALL go to IDLE.
REQ-018 While tx_ready=0, tx_valid SHALL be ignored and tx_data changes SHALL NOT affect the frame in flight or the held byte.
REQ-019 A new byte SHALL be acceptable from the cycle after the holding register drains, even mid-frame.
REQ-020 busy SHALL equal (state != IDLE) || hold_full.

Reset
REQ-021 While rst=0: tx=1, tx_ready=1, busy=0, state=IDLE, hold_full=0, baud counter=0, bit index=0, regardless of clock.
REQ-022 Reset asserted mid-frame SHALL abort the frame and discard the held byte; no partial frame SHALL resume after release.
REQ-023 The first handshake SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-024 A shared package uart_pkg SHALL hold the state enum, DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1; the receiver SHALL reuse it.
REQ-025 The baud counter SHALL be a sub-module uart_baud_gen (inputs clk, rst, enable; output bit_tick), shareable with the receiver.

Verification (CLKS_PER_BIT=4)
REQ-026 Send 0xA5, PARITY_EN=0 -> tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; start bit begins 1 cycle after the accepting edge; busy falls after 40 cycles.
REQ-027 Send 0x00 then 0xFF back-to-back -> second start bit immediately follows the first stop bit; tx_ready low only while a byte is held.
REQ-028 PARITY_EN=1, send 0x07 -> parity bit 1, 11-bit frame of 44 cycles; send 0x03 -> parity bit 0.
REQ-029 Assert rst during data bit 3 of 0x5A with a second byte held -> tx=1, tx_ready=1, busy=0 immediately; after release the line stays high with no frame.
REQ-030 Hold tx_valid=1 and change tx_data every cycle while tx_ready=0 -> only the values present at the accepting edges are transmitted.
REQ-031 Loop tx into the team receiver's Rx for bytes 0x00, 0x55, 0xFF -> the receiver reports each byte unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and parity helper.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap cycle.
// Held at zero while disabled so every frame starts on a fresh bit boundary.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned     CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign bit_tick = enable && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!enable || bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register and optional even parity.
// Frame: start, 8 data bits LSB first, [parity], stop; each bit CLKS_PER_BIT cycles.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    uart_state_e          r_state;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;

    logic w_tick;
    logic w_baud_en;
    logic w_accept;
    logic w_load;
    logic w_hold_full_nxt;
    logic w_idle_nxt;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_baud_en),
        .bit_tick(w_tick)
    );

    // Handshake and holding-register bookkeeping; accept and load never coincide.
    assign w_baud_en       = (r_state != ST_IDLE);
    assign w_accept        = tx_valid && r_ready;
    assign w_load          = r_hold_full &&
                             ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));
    assign w_hold_full_nxt = w_accept || (r_hold_full && !w_load);
    assign w_idle_nxt      = !r_hold_full &&
                             ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_idx       <= '0;
            r_tx        <= STOP_BIT;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= tx_data;
            end
            r_hold_full <= w_hold_full_nxt;
            r_ready     <= !w_hold_full_nxt;
            r_busy      <= !w_idle_nxt || w_hold_full_nxt;

            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_state  <= ST_START;
                        r_tx     <= START_BIT;
                        r_shift  <= r_hold;
                        r_parity <= even_parity(r_hold);
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_idx <= '0;
                            if (PARITY_EN) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= STOP_BIT;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_tx    <= STOP_BIT;
                    end
                end
                ST_STOP: begin
                    // A held byte chains straight into the next start bit.
                    if (w_tick) begin
                        if (r_hold_full) begin
                            r_state  <= ST_START;
                            r_tx     <= START_BIT;
                            r_shift  <= r_hold;
                            r_parity <= even_parity(r_hold);
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= STOP_BIT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= STOP_BIT;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: one instance without parity, one with.
// The serial line is logged every cycle and frames are checked against hand-derived bits.
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int          LOG_N = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       ready0, tx0, busy0;
    logic       ready1, tx1, busy1;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0),
        .tx_ready(ready0), .tx(tx0), .busy(busy0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
        .tx_ready(ready1), .tx(tx1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle line log; index n holds the value seen after rising edge n.
    logic tx0_log [LOG_N];
    logic busy0_log [LOG_N];
    logic ready0_log [LOG_N];
    logic tx1_log [LOG_N];
    logic busy1_log [LOG_N];

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            tx0_log[cyc]    = tx0;
            busy0_log[cyc]  = busy0;
            ready0_log[cyc] = ready0;
            tx1_log[cyc]    = tx1;
            busy1_log[cyc]  = busy1;
        end
    end

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a byte and return the index of the accepting edge (bounded wait).
    task automatic send(input int sel, input logic [7:0] b, output int acc);
        logic w;
        int   n;
        n   = 0;
        acc = -1;
        if (sel == 0) begin v0 = 1'b1; d0 = b; end
        else          begin v1 = 1'b1; d1 = b; end
        while (acc < 0 && n < 200) begin
            w = (sel == 0) ? ready0 : ready1;
            @(posedge clk);
            #1;
            if (w) acc = cyc;
            n++;
        end
        if (sel == 0) v0 = 1'b0;
        else          v1 = 1'b0;
        if (acc < 0) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int sel, input int start,
                               input logic [7:0] b, input bit par_en, input logic par);
        logic exp_bits [11];
        int   nb;
        logic obs;
        nb = par_en ? 11 : 10;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        if (par_en) exp_bits[9] = par;
        exp_bits[nb-1] = 1'b1;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                obs = (sel == 0) ? tx0_log[start + k*CPB + c] : tx1_log[start + k*CPB + c];
                chk($sformatf("%s_bit%0d_c%0d", tag, k, c), 32'(obs), 32'(exp_bits[k]));
            end
        end
    endtask

    // Reference receiver: find the falling edge, sample each bit mid-period.
    task automatic rx_byte(input int from, output int start, output logic [7:0] b,
                           output logic stop);
        start = -1;
        b     = 8'h00;
        stop  = 1'b0;
        for (int i = (from < 1 ? 1 : from); i < LOG_N - 48 && start < 0; i++) begin
            if (tx0_log[i-1] === 1'b1 && tx0_log[i] === 1'b0) start = i;
        end
        if (start >= 0) begin
            for (int k = 0; k < 8; k++) b[k] = tx0_log[start + (k+1)*CPB + 2];
            stop = tx0_log[start + 9*CPB + 2];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rel, acc, a1, a2, c1, c2, r1, r2, rd, e0, f1, s;
        logic [7:0] rb;
        logic rstop, ok;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx0", 32'(tx0), 32'd1);
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_tx1", 32'(tx1), 32'd1);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd0);

        // 0xA5, no parity, accepted on the first edge after release
        @(negedge clk);
        rst = 1'b1;
        rel = cyc;
        send(0, 8'hA5, acc);
        chk("first_accept_edge", 32'(acc), 32'(rel + 1));
        chk("a5_ready_low", 32'(ready0), 32'd0);
        chk("a5_busy_high", 32'(busy0), 32'd1);
        wait_cyc(acc + 43);
        check_frame("a5", 0, acc + 1, 8'hA5, 1'b0, 1'b0);
        chk("a5_idle_before_start", 32'(tx0_log[acc]), 32'd1);
        chk("a5_busy_last", 32'(busy0_log[acc + 40]), 32'd1);
        chk("a5_busy_fall", 32'(busy0_log[acc + 41]), 32'd0);
        chk("a5_line_idle", 32'(tx0_log[acc + 41]), 32'd1);

        // 0x00 then 0xFF back-to-back
        send(0, 8'h00, a1);
        send(0, 8'hFF, a2);
        chk("b2b_second_accept", 32'(a2), 32'(a1 + 2));
        wait_cyc(a1 + 83);
        check_frame("b00", 0, a1 + 1, 8'h00, 1'b0, 1'b0);
        check_frame("bff", 0, a1 + 41, 8'hFF, 1'b0, 1'b0);
        chk("b2b_ready_held1", 32'(ready0_log[a1]), 32'd0);
        chk("b2b_ready_drain1", 32'(ready0_log[a1 + 1]), 32'd1);
        chk("b2b_ready_held2", 32'(ready0_log[a2]), 32'd0);
        chk("b2b_ready_held2_late", 32'(ready0_log[a1 + 40]), 32'd0);
        chk("b2b_ready_drain2", 32'(ready0_log[a1 + 41]), 32'd1);
        chk("b2b_busy_last", 32'(busy0_log[a1 + 80]), 32'd1);
        chk("b2b_busy_fall", 32'(busy0_log[a1 + 81]), 32'd0);

        // Even parity: 0x07 -> 1, 0x03 -> 0
        send(1, 8'h07, c1);
        wait_cyc(c1 + 47);
        check_frame("p07", 1, c1 + 1, 8'h07, 1'b1, 1'b1);
        chk("p07_busy_last", 32'(busy1_log[c1 + 44]), 32'd1);
        chk("p07_busy_fall", 32'(busy1_log[c1 + 45]), 32'd0);
        send(1, 8'h03, c2);
        wait_cyc(c2 + 47);
        check_frame("p03", 1, c2 + 1, 8'h03, 1'b1, 1'b0);

        // Reset during data bit 3 of 0x5A with 0x33 held
        send(0, 8'h5A, r1);
        send(0, 8'h33, r2);
        wait_cyc(r1 + 18);
        chk("rstmid_bit3", 32'(tx0), 32'd1);
        chk("rstmid_held", 32'(ready0), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstmid_tx", 32'(tx0), 32'd1);
        chk("rstmid_ready", 32'(ready0), 32'd1);
        chk("rstmid_busy", 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd = cyc;
        wait_cyc(rd + 61);
        ok = 1'b1;
        for (int i = rd; i < rd + 60; i++) if (tx0_log[i] !== 1'b1) ok = 1'b0;
        chk("rstmid_line_stays_high", 32'(ok), 32'd1);
        ok = 1'b1;
        for (int i = rd; i < rd + 60; i++) if (busy0_log[i] !== 1'b0) ok = 1'b0;
        chk("rstmid_no_busy", 32'(ok), 32'd1);

        // tx_valid held, tx_data changing each cycle: accepts at e0, e0+2, e0+42
        v0 = 1'b1;
        d0 = 8'h0B;
        @(posedge clk);
        #1;
        e0 = cyc;
        for (int i = 1; i <= 42; i++) begin
            d0 = 8'(i * 37 + 11);
            @(posedge clk);
            #1;
        end
        v0 = 1'b0;
        wait_cyc(e0 + 123);
        check_frame("chg0", 0, e0 + 1, 8'h0B, 1'b0, 1'b0);
        check_frame("chg1", 0, e0 + 41, 8'h55, 1'b0, 1'b0);
        check_frame("chg2", 0, e0 + 81, 8'h1D, 1'b0, 1'b0);
        chk("chg_idle_after", 32'(busy0_log[e0 + 121]), 32'd0);

        // Loopback through the reference receiver
        send(0, 8'h00, f1);
        send(0, 8'h55, acc);
        send(0, 8'hFF, acc);
        wait_cyc(f1 + 125);
        rx_byte(f1, s, rb, rstop);
        chk("rx0_start", 32'(s), 32'(f1 + 1));
        chk("rx0_data", 32'(rb), 32'h00);
        chk("rx0_stop", 32'(rstop), 32'd1);
        rx_byte(s + 40, s, rb, rstop);
        chk("rx1_data", 32'(rb), 32'h55);
        chk("rx1_stop", 32'(rstop), 32'd1);
        rx_byte(s + 40, s, rb, rstop);
        chk("rx2_data", 32'(rb), 32'hFF);
        chk("rx2_stop", 32'(rstop), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
